// File: rtl/lcd_pkg.sv
// Shared constants and helpers for the HD44780-style LCD responder:
// instruction opcodes, DDRAM line geometry, address-counter stepping and mapping.
package lcd_pkg;

  localparam logic [7:0] LCD_INIT1 = 8'h38;  // function set: 8-bit, 2 lines, 5x8
  localparam logic [7:0] LCD_INIT2 = 8'h0C;  // display on, cursor off, blink off
  localparam logic [7:0] LCD_INIT3 = 8'h06;  // entry mode: increment, no shift
  localparam logic [7:0] LCD_INIT4 = 8'h01;  // clear display
  localparam logic [7:0] LCD_INIT5 = 8'h80;  // DDRAM address 0

  localparam logic [7:0] LCD_BLANK = 8'h20;

  // Line 1 ends at 0x27, line 2 spans 0x40..0x67.
  localparam logic [6:0] AC_L1_END   = 7'h27;
  localparam logic [6:0] AC_L2_START = 7'h40;
  localparam logic [6:0] AC_L2_END   = 7'h67;

  localparam int DEF_CMD_CYCLES   = 2000;   // 40 us @ 50 MHz
  localparam int DEF_CLEAR_CYCLES = 82000;  // 1.64 ms @ 50 MHz

  // Result of mapping an AC value onto the 32 visible cells.
  typedef struct packed {
    logic       hit;
    logic [4:0] idx;
  } ddram_map_t;

  // Step the address counter, hopping the gap between the two lines.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac == AC_L1_END)      nxt = AC_L2_START;
      else if (ac == AC_L2_END) nxt = 7'h00;
      else                      nxt = ac + 7'd1;
    end else begin
      if (ac == 7'h00)             nxt = AC_L2_END;
      else if (ac == AC_L2_START)  nxt = AC_L1_END;
      else                         nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

  // Only the first 16 positions of each line are visible cells.
  function automatic ddram_map_t ac_to_idx(input logic [6:0] ac);
    ddram_map_t m;
    m.hit = 1'b0;
    m.idx = 5'd0;
    if (ac[6:4] == 3'b000) begin
      m.hit = 1'b1;
      m.idx = {1'b0, ac[3:0]};
    end else if (ac[6:4] == 3'b100) begin
      m.hit = 1'b1;
      m.idx = {1'b1, ac[3:0]};
    end
    return m;
  endfunction

endpackage

// File: rtl/lcd_ddram_32x8.sv
// 32x8 character image: one write port, single-cycle bulk clear to blank,
// two combinational read ports (bus side and debug side).
module lcd_ddram_32x8
  import lcd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we,
  input  logic [4:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic       i_clr,
  input  logic [4:0] i_raddr_a,
  output logic [7:0] o_rdata_a,
  input  logic [4:0] i_raddr_b,
  output logic [7:0] o_rdata_b
);

  logic [31:0][7:0] r_mem;

  // Reset and clear both blank every cell; otherwise take the single write.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_mem <= {32{LCD_BLANK}};
    else if (i_we)      r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Panel end of an HD44780-style 8-bit LCD bus. Synchronizes the bus, commits
// accesses on the falling edge of EN, keeps AC/entry/display state and a busy
// timer, and serves status and data reads.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int CMD_CYCLES   = DEF_CMD_CYCLES,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA_IN,
  output logic [7:0] LCD_DATA_OUT,
  output logic       LCD_DATA_OE,
  input  logic [4:0] dbg_idx,
  output logic [7:0] dbg_char,
  output logic       busy,
  output logic [6:0] addr_counter,
  output logic [2:0] disp_ctrl,
  output logic       protocol_err
);

  localparam int MAXC  = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] CMD_LD = CNT_W'(CMD_CYCLES);
  localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(CLEAR_CYCLES);

  // {EN, RS, RW, DATA} travel together through the synchronizer.
  logic [SYNC_STAGES-1:0][10:0] r_sync;
  logic [10:0]      w_bus_in;
  logic             w_en, w_rs, w_rw;
  logic [7:0]       w_d;
  logic             r_en_prev;
  logic             w_fall, w_status, w_acc, w_rej;
  logic             w_clr, w_we;
  ddram_map_t       w_map;
  logic [7:0]       w_ram_a, w_rd_char;

  logic [6:0]       r_ac;
  logic             r_id, r_shift, r_cgram;
  logic [2:0]       r_disp;
  logic [CNT_W-1:0] r_busy_cnt;
  logic             r_perr, r_oe;
  logic [7:0]       r_dout;
  logic             w_unused_shift;

  assign w_bus_in = {LCD_EN, LCD_RS, LCD_RW, LCD_DATA_IN};

  // Plain multi-flop synchronizer for the whole bus.
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], w_bus_in};
  end

  assign {w_en, w_rs, w_rw, w_d} = r_sync[SYNC_STAGES-1];

  assign busy     = (r_busy_cnt != '0);
  assign w_fall   = r_en_prev & ~w_en;
  assign w_status = ~w_rs & w_rw;
  // Status reads are the only access allowed through while busy.
  assign w_acc    = w_fall & (~busy | w_status);
  assign w_rej    = w_fall & busy & ~w_status;

  assign w_map     = ac_to_idx(r_ac);
  assign w_rd_char = w_map.hit ? w_ram_a : LCD_BLANK;
  assign w_clr     = w_acc & ~w_rs & ~w_rw & (w_d == 8'h01);
  assign w_we      = w_acc & w_rs & ~w_rw & ~r_cgram & w_map.hit;

  // S is held for completeness; display shift is not modelled.
  assign w_unused_shift = r_shift;

  lcd_ddram_32x8 u_ddram (
    .i_clk     (CLOCK_50),
    .i_rst     (reset),
    .i_we      (w_we),
    .i_waddr   (w_map.idx),
    .i_wdata   (w_d),
    .i_clr     (w_clr),
    .i_raddr_a (w_map.idx),
    .o_rdata_a (w_ram_a),
    .i_raddr_b (dbg_idx),
    .o_rdata_b (dbg_char)
  );

  // Access commit: instruction decode on the highest set bit, data
  // write/read AC stepping, busy timer and sticky error flag.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_en_prev  <= 1'b0;
      r_ac       <= 7'h00;
      r_id       <= 1'b1;
      r_shift    <= 1'b0;
      r_disp     <= 3'b000;
      r_cgram    <= 1'b0;
      r_busy_cnt <= '0;
      r_perr     <= 1'b0;
    end else begin
      r_en_prev <= w_en;
      if (busy) r_busy_cnt <= r_busy_cnt - CNT_W'(1);
      if (w_rej) r_perr <= 1'b1;
      if (w_acc && !w_rs && !w_rw) begin
        if (w_d[7]) begin
          r_ac       <= w_d[6:0];
          r_cgram    <= 1'b0;
          r_busy_cnt <= CMD_LD;
        end else if (w_d[6]) begin
          r_cgram    <= 1'b1;
          r_busy_cnt <= CMD_LD;
        end else if (w_d[5]) begin
          if (!w_d[4]) r_perr <= 1'b1;
          r_busy_cnt <= CMD_LD;
        end else if (w_d[4]) begin
          if (!w_d[3]) r_ac <= ac_step(r_ac, w_d[2]);
          r_busy_cnt <= CMD_LD;
        end else if (w_d[3]) begin
          r_disp     <= w_d[2:0];
          r_busy_cnt <= CMD_LD;
        end else if (w_d[2]) begin
          r_id       <= w_d[1];
          r_shift    <= w_d[0];
          r_busy_cnt <= CMD_LD;
        end else if (w_d[1]) begin
          r_ac       <= 7'h00;
          r_busy_cnt <= CLR_LD;
        end else if (w_d[0]) begin
          r_ac       <= 7'h00;
          r_id       <= 1'b1;
          r_busy_cnt <= CLR_LD;
        end
      end else if (w_acc && w_rs) begin
        // CGRAM-mode data writes are discarded without moving AC.
        if (!(r_cgram && !w_rw)) r_ac <= ac_step(r_ac, r_id);
        r_busy_cnt <= CMD_LD;
      end
    end
  end

  // Read path: drive while EN and RW are high, one cycle behind the bus.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_oe   <= 1'b0;
      r_dout <= 8'h00;
    end else begin
      r_oe <= w_en & w_rw;
      if (w_en && w_rw) r_dout <= w_rs ? w_rd_char : {busy, r_ac};
    end
  end

  assign LCD_DATA_OUT = r_dout;
  assign LCD_DATA_OE  = r_oe;
  assign addr_counter = r_ac;
  assign disp_ctrl    = r_disp;
  assign protocol_err = r_perr;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for the LCD responder. Read data is checked by a scoreboard
// monitor on each OE rising edge; state is checked directly between accesses.
module tb_lcd_hd44780_responder;
  import lcd_pkg::*;

  localparam int CMD = 20;
  localparam int CLR = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, rs = 1'b0, rw = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       oe;
  logic [4:0] dbg_idx = 5'd0;
  logic [7:0] dbg_char;
  logic       busy;
  logic [6:0] ac;
  logic [2:0] disp;
  logic       perr;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #10 clk = ~clk;

  lcd_hd44780_responder #(
    .CMD_CYCLES  (CMD),
    .CLEAR_CYCLES(CLR),
    .SYNC_STAGES (2)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .LCD_EN      (en),
    .LCD_RS      (rs),
    .LCD_RW      (rw),
    .LCD_DATA_IN (din),
    .LCD_DATA_OUT(dout),
    .LCD_DATA_OE (oe),
    .dbg_idx     (dbg_idx),
    .dbg_char    (dbg_char),
    .busy        (busy),
    .addr_counter(ac),
    .disp_ctrl   (disp),
    .protocol_err(perr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every new read drive pops one expected byte.
  logic oe_prev = 1'b0;
  always @(negedge clk) begin
    if (oe === 1'b1 && oe_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL read_unexpected actual=%0h expected=none", dout);
      end else begin
        chk("read_data", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
    oe_prev = oe;
  end

  task automatic bus(input logic r_s, input logic r_w, input logic [7:0] d);
    @(posedge clk); #1;
    rs = r_s; rw = r_w; din = d; en = 1'b1;
    repeat (5) @(posedge clk);
    #1 en = 1'b0;
    repeat (4) @(posedge clk);
    #1 rs = 1'b0; rw = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout actual=busy expected=idle");
    end
  endtask

  task automatic wr_ins(input logic [7:0] d);
    wait_idle();
    bus(1'b0, 1'b0, d);
  endtask

  task automatic wr_dat(input logic [7:0] d);
    wait_idle();
    bus(1'b1, 1'b0, d);
  endtask

  task automatic rd(input logic r_s, input logic [7:0] exp);
    exp_q.push_back(exp);
    bus(r_s, 1'b1, 8'h00);
  endtask

  task automatic chk_cell(input int i, input logic [7:0] exp);
    dbg_idx = 5'(i);
    #1 chk($sformatf("dbg_char[%0d]", i), 32'(dbg_char), 32'(exp));
  endtask

  task automatic chk_all_blank(input string tag);
    int bad = 0;
    for (int i = 0; i < 32; i++) begin
      dbg_idx = 5'(i);
      #1 if (dbg_char !== LCD_BLANK) bad++;
    end
    chk({tag, "_nonblank_cells"}, 32'(bad), 32'd0);
  endtask

  // Issue a clear and count the cycles busy stays high after it.
  task automatic clear_measure();
    int n = 0;
    int guard = 0;
    bit seen = 0;
    wait_idle();
    @(posedge clk); #1;
    rs = 1'b0; rw = 1'b0; din = LCD_INIT4; en = 1'b1;
    repeat (5) @(posedge clk);
    #1 en = 1'b0;
    while (guard < CLR + 200) begin
      @(negedge clk);
      guard++;
      if (busy === 1'b1) begin
        seen = 1;
        n++;
      end else if (seen) break;
    end
    chk("clear_busy_cycles", 32'(n), 32'(CLR));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_all_blank("reset");
    chk("reset_ac", 32'(ac), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_oe", 32'(oe), 32'h0);
    chk("reset_perr", 32'(perr), 32'h0);
    chk("reset_disp", 32'(disp), 32'h0);

    // 2. Init sequence; clear busy window length
    wr_ins(LCD_INIT1);
    wr_ins(LCD_INIT2);
    wr_ins(LCD_INIT3);
    clear_measure();
    chk("init_disp", 32'(disp), 32'h4);
    chk("init_perr", 32'(perr), 32'h0);
    chk_all_blank("init");

    // 3. Line 1 writes, dropped write at 0x27, wrap into line 2
    wr_ins(LCD_INIT5);
    wr_dat(8'h48);
    wr_dat(8'h49);
    wait_idle();
    chk_cell(0, 8'h48);
    chk_cell(1, 8'h49);
    chk("ac_after_hi", 32'(ac), 32'h02);
    wr_ins(8'hA7);
    wr_dat(8'h41);
    wait_idle();
    chk("ac_wrap_27_40", 32'(ac), 32'h40);
    chk_cell(16, 8'h20);
    chk_cell(15, 8'h20);
    wr_dat(8'h42);
    wait_idle();
    chk_cell(16, 8'h42);
    chk("ac_after_42", 32'(ac), 32'h41);

    // 4. Accesses inside a clear window are rejected; status read still served
    wait_idle();
    bus(1'b0, 1'b0, 8'h01);
    repeat (10) @(posedge clk);
    bus(1'b0, 1'b0, 8'h80);
    bus(1'b1, 1'b0, 8'h55);
    @(negedge clk);
    chk("busy_in_clear", 32'(busy), 32'h1);
    chk("perr_rejected", 32'(perr), 32'h1);
    chk("ac_in_clear", 32'(ac), 32'h0);
    chk_cell(0, 8'h20);
    rd(1'b0, 8'h80);

    // 5. Data reads with increment then decrement, including unmapped AC
    wr_ins(8'hC0);
    wr_dat(8'h42);
    wr_ins(8'hC0);
    wait_idle();
    rd(1'b1, 8'h42);
    wait_idle();
    chk("ac_rd_inc", 32'(ac), 32'h41);
    wr_ins(8'h04);
    wait_idle();
    rd(1'b1, 8'h20);
    wait_idle();
    chk("ac_rd_dec", 32'(ac), 32'h40);
    rd(1'b1, 8'h42);
    wait_idle();
    chk("ac_wrap_40_27", 32'(ac), 32'h27);
    rd(1'b1, 8'h20);
    wait_idle();
    chk("ac_unmapped_rd", 32'(ac), 32'h26);
    wr_ins(8'h80);
    wr_ins(8'h10);
    wait_idle();
    chk("ac_wrap_00_67", 32'(ac), 32'h67);
    wr_ins(8'h14);
    wait_idle();
    chk("ac_wrap_67_00", 32'(ac), 32'h00);
    wr_ins(8'h18);
    wait_idle();
    chk("ac_shift_noop", 32'(ac), 32'h00);
    wr_ins(8'h30);
    wait_idle();
    chk("perr_dl8", 32'(perr), 32'h1);

    // 6. Reset in the middle of a clear
    wr_ins(8'h85);
    wr_dat(8'h77);
    wait_idle();
    chk_cell(5, 8'h77);
    bus(1'b0, 1'b0, 8'h01);
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_ac", 32'(ac), 32'h0);
    chk("rst_mid_perr", 32'(perr), 32'h0);
    chk_all_blank("rst_mid");
    bus(1'b0, 1'b0, 8'h85);
    @(negedge clk);
    chk("post_rst_ac", 32'(ac), 32'h05);
    chk("post_rst_busy", 32'(busy), 32'h1);
    chk("post_rst_perr", 32'(perr), 32'h0);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
